ddr_req_queue: RTL and testbench
================================

# ddr_req_queue

Host-side request queue directly upstream of the DDR controller top level. It buffers read/write requests from the host/stimulus side in a FIFO and issues them one at a time. For each request it presents the request fields and a one-cycle `act_cmd` pulse, then tracks the controller's `dev_busy` handshake before issuing the next request. It also detects a controller that never acknowledges an issued command.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `ADDR_W`, 32: request address width.
- `DATA_W`, 64: write data width.
- `BUSY_TMO`, 16: cycles allowed for `dev_busy` to rise after `act_cmd`.
- `clock_t`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `host_valid`  in  1  host request present.
- `host_ready`  out  1  queue can accept (`count < DEPTH`).
- `host_rw`  in  1  1 = write, 0 = read.
- `host_addr`  in  ADDR_W  request address.
- `host_data`  in  DATA_W  write data; don't-care for reads.
- `dev_busy`  in  1  controller busy, from DDR top level.
- `act_cmd`  out  1  one-cycle issue strobe to DDR top level.
- `out_rw`, `out_addr`, `out_data`  out  1/ADDR_W/DATA_W  issued request; held stable from the issue cycle until the next issue.
- `q_count`  out  $clog2(DEPTH)+1  current occupancy.
- `tmo_err`  out  1  sticky; set on a handshake timeout.
- `rd_cnt`, `wr_cnt`  out  16  issued-command counters (see Configuration).

## Operation
- Push: `host_valid && host_ready` writes `{rw,addr,data}` at the write pointer on the rising edge.
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH.
- FSM states are IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
- IDLE: if queue non-empty and `!dev_busy`:
  - pop the head into the `out_*` registers;
  - transition to ISSUE.
- ISSUE: `act_cmd`=1 for this one cycle; clear the timeout counter; transition to WAIT_BUSY.
- WAIT_BUSY:
  - `dev_busy`=1 → WAIT_DONE.
  - Otherwise the timeout counter increments. When it reaches BUSY_TMO-1, set `tmo_err` and go to IDLE; the request is dropped, not retried.
- WAIT_DONE: on `dev_busy`=0 → IDLE.
- Push and pop in the same cycle: occupancy is unchanged, and both operations take effect.
- A push to an empty queue is never bypassed; the entry is popped no earlier than the next edge.
- Full queue: `host_ready`=0. Pushes are ignored, and no data is corrupted.
- `dev_busy` high while in IDLE (foreign busy): no issue takes place until it falls.
- `tmo_err` is cleared only by `reset`.

## Timing
- Reset values:
  - `host_ready`=1;
  - `act_cmd`=0;
  - `out_rw`=0, `out_addr`=0, `out_data`=0;
  - `q_count`=0;
  - `tmo_err`=0;
  - `rd_cnt`=0, `wr_cnt`=0;
  - FSM in IDLE;
  - pointers at 0.
- Reset asserted mid-operation flushes the queue and forces IDLE asynchronously. `act_cmd` drops immediately.
- All outputs are registered, except `host_ready`, which is derived combinationally from the registered `q_count`.
- Latency with an idle controller:
  - request accepted at edge N;
  - pop at edge N+1;
  - `act_cmd` high from edge N+1 to edge N+2.
- Minimum spacing between two `act_cmd` pulses is 4 cycles: ISSUE, WAIT_BUSY, WAIT_DONE, IDLE.
- `out_*` change only on the pop edge.

## Configuration
- `DDR_REQ_STATS_EN` defined:
  - `rd_cnt` increments when a read is issued; `wr_cnt` increments when a write is issued;
  - both update on the ISSUE cycle;
  - both saturate at 16'hFFFF.
- Not defined: the counter logic is absent, and `rd_cnt`/`wr_cnt` are tied to 0. The ports remain present.

## Test plan
- Single write:
  - stimulus: addr 0x100, data 0xDEAD_BEEF, with `dev_busy` rising 2 cycles after `act_cmd` and falling 5 cycles later;
  - required: one `act_cmd` pulse at edge N+1, `out_addr`=0x100, `out_data`=0xDEAD_BEEF; FSM returns to IDLE; `q_count`=0.
- Fill:
  - stimulus: 10 back-to-back pushes with `dev_busy` held high;
  - required: 8 accepted; `host_ready`=0 after the 8th; pushes 9–10 dropped; `q_count`=8.
- Drain order:
  - stimulus: after the fill, `dev_busy` handshakes normally;
  - required: 8 `act_cmd` pulses, FIFO order, spaced at least 4 cycles apart.
- Timeout:
  - stimulus: `dev_busy` never rises after issue;
  - required: `tmo_err`=1 exactly BUSY_TMO cycles after WAIT_BUSY entry; the next queued request issues afterwards.
- Reset mid-operation:
  - stimulus: assert `reset` in WAIT_DONE with 3 entries queued;
  - required: `q_count`=0, `act_cmd`=0, FSM in IDLE; no issue after release until a new push.
- Stats (with `DDR_REQ_STATS_EN`):
  - stimulus: issue 3 reads and 2 writes;
  - required: `rd_cnt`=3, `wr_cnt`=2. Without the macro both read 0.

Source files
------------

// File: rtl/ddr_req_queue.sv
// ddr_req_queue: host-side request FIFO ahead of the DDR controller.
// Requests are queued and issued one at a time with a single-cycle act_cmd
// strobe, then tracked through the controller's dev_busy rise and fall.
// A controller that never raises dev_busy after an issue trips a sticky
// tmo_err, and that request is dropped.
// Optional feature: define DDR_REQ_STATS_EN to enable the saturating
// rd_cnt/wr_cnt issued-command counters. When it is undefined, both ports read 0.
module ddr_req_queue #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int BUSY_TMO = 16
) (
  input  logic                     clock_t,
  input  logic                     reset,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     host_rw,
  input  logic [ADDR_W-1:0]        host_addr,
  input  logic [DATA_W-1:0]        host_data,
  input  logic                     dev_busy,
  output logic                     act_cmd,
  output logic                     out_rw,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     tmo_err,
  output logic [15:0]              rd_cnt,
  output logic [15:0]              wr_cnt
);

  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam int TMO_W   = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       r_count;
  logic [ENTRY_W-1:0]  r_mem [DEPTH];
  logic                r_act_cmd;
  logic                r_out_rw;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic                r_tmo_err;

  logic                w_push;
  logic                w_pop;
  logic                w_tmo_clr;
  logic                w_tmo_inc;
  logic                w_tmo_set;
  logic [ENTRY_W-1:0]  w_head;

  // host_ready comes straight from the registered occupancy; a pop in the
  // same cycle does not open a slot early.
  assign host_ready = (r_count < PW'(DEPTH));
  assign w_push     = host_valid && host_ready;
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

  assign act_cmd  = r_act_cmd;
  assign out_rw   = r_out_rw;
  assign out_addr = r_out_addr;
  assign out_data = r_out_data;
  assign q_count  = r_count;
  assign tmo_err  = r_tmo_err;

  // FSM state register
  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and per-state control strobes
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tmo_clr    = 1'b0;
    w_tmo_inc    = 1'b0;
    w_tmo_set    = 1'b0;
    case (r_state)
      IDLE: begin
        // Pop uses the registered count, so a fresh push is never bypassed.
        if ((r_count != '0) && !dev_busy) begin
          w_pop        = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_tmo_clr    = 1'b1;
        w_state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (dev_busy) begin
          w_state_next = WAIT_DONE;
        end else if (r_tmo_cnt == TMO_W'(BUSY_TMO - 1)) begin
          w_tmo_set    = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_tmo_inc    = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!dev_busy) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FIFO pointers and occupancy; the pointer MSB separates full from empty
  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read
  always_ff @(posedge clock_t) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {host_rw, host_addr, host_data};
  end

  // Issued request and strobe; out_* change only on the pop edge
  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      r_act_cmd  <= 1'b0;
      r_out_rw   <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_act_cmd <= (w_state_next == ISSUE);
      if (w_pop) {r_out_rw, r_out_addr, r_out_data} <= w_head;
    end
  end

  // Handshake timeout counter and sticky error flag
  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (w_tmo_clr)      r_tmo_cnt <= '0;
      else if (w_tmo_inc) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_tmo_set)      r_tmo_err <= 1'b1;
    end
  end

`ifdef DDR_REQ_STATS_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  // Saturating issued-command counters, advanced on the ISSUE cycle
  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (r_state == ISSUE) begin
      if (r_out_rw) begin
        if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      end else begin
        if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      end
    end
  end

  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;
`else
  assign rd_cnt = 16'd0;
  assign wr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ddr_req_queue.sv
// Directed bench for ddr_req_queue: reset values, single write, fill,
// drain order, handshake timeout, reset mid-operation and issue statistics.
module tb_ddr_req_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic        host_rw = 1'b0;
  logic [31:0] host_addr = '0;
  logic [63:0] host_data = '0;
  logic        dev_busy;
  logic        act_cmd;
  logic        out_rw;
  logic [31:0] out_addr;
  logic [63:0] out_data;
  logic [3:0]  q_count;
  logic        tmo_err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Controller model: forced level plus an automatic handshake responder
  logic force_busy = 1'b0;
  logic resp_busy  = 1'b0;
  logic resp_en    = 1'b0;
  assign dev_busy = force_busy | resp_busy;

  // Issue monitor
  logic [31:0] mon_addr[$];
  logic [63:0] mon_data[$];
  logic        mon_rw[$];
  int          mon_cyc[$];

  ddr_req_queue #(.DEPTH(8), .ADDR_W(32), .DATA_W(64), .BUSY_TMO(16)) dut (
    .clock_t(clk), .reset(reset), .host_valid(host_valid), .host_ready(host_ready),
    .host_rw(host_rw), .host_addr(host_addr), .host_data(host_data),
    .dev_busy(dev_busy), .act_cmd(act_cmd), .out_rw(out_rw), .out_addr(out_addr),
    .out_data(out_data), .q_count(q_count), .tmo_err(tmo_err),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (act_cmd === 1'b1) begin
      mon_addr.push_back(out_addr);
      mon_data.push_back(out_data);
      mon_rw.push_back(out_rw);
      mon_cyc.push_back(cyc);
    end
  end

  // Responder: busy rises 2 cycles after act_cmd and stays high 5 cycles
  always begin
    @(negedge clk);
    if (resp_en && act_cmd === 1'b1) begin
      repeat (2) @(negedge clk);
      resp_busy = 1'b1;
      repeat (5) @(negedge clk);
      resp_busy = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mon_clear();
    mon_addr.delete(); mon_data.delete(); mon_rw.delete(); mon_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_host_ready: got %0b expected 1", host_ready); end
    n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL reset_act_cmd: got %0b expected 0", act_cmd); end
    n_checks++; if (out_rw !== 1'b0) begin n_fail++; $display("FAIL reset_out_rw: got %0b expected 0", out_rw); end
    n_checks++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL reset_out_addr: got %0h expected 0", out_addr); end
    n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    n_checks++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL reset_q_count: got %0d expected 0", q_count); end
    n_checks++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo_err: got %0b expected 0", tmo_err); end
    n_checks++; if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", rd_cnt, wr_cnt); end
  endtask

  task automatic test_single_write();
    resp_en = 1'b1;
    mon_clear();
    host_valid = 1'b1; host_rw = 1'b1; host_addr = 32'h100; host_data = 64'hDEAD_BEEF;
    tick();  // edge N: accepted
    host_valid = 1'b0;
    n_checks++; if (q_count !== 4'd1) begin n_fail++; $display("FAIL sw_count_after_push: got %0d expected 1", q_count); end
    n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL sw_no_bypass: got %0b expected 0", act_cmd); end
    tick();  // edge N+1: pop and issue
    n_checks++; if (act_cmd !== 1'b1) begin n_fail++; $display("FAIL sw_act_n1: got %0b expected 1", act_cmd); end
    n_checks++; if (out_addr !== 32'h100) begin n_fail++; $display("FAIL sw_out_addr: got %0h expected 100", out_addr); end
    n_checks++; if (out_data !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_out_data: got %0h expected deadbeef", out_data); end
    n_checks++; if (out_rw !== 1'b1) begin n_fail++; $display("FAIL sw_out_rw: got %0b expected 1", out_rw); end
    n_checks++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL sw_count_after_pop: got %0d expected 0", q_count); end
    tick();  // edge N+2: strobe ends
    n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL sw_act_n2: got %0b expected 0", act_cmd); end
    repeat (15) tick();
    n_checks++; if (mon_addr.size() !== 1) begin n_fail++; $display("FAIL sw_pulse_count: got %0d expected 1", mon_addr.size()); end
    n_checks++; if (out_addr !== 32'h100) begin n_fail++; $display("FAIL sw_out_held: got %0h expected 100", out_addr); end
  endtask

  task automatic test_fill();
    int exp_cnt;
    resp_en = 1'b0; force_busy = 1'b1;
    mon_clear();
    for (int i = 0; i < 10; i++) begin
      host_valid = 1'b1; host_rw = i[0]; host_addr = 32'h200 + i; host_data = 64'(i);
      tick();
      exp_cnt = (i + 1 > 8) ? 8 : i + 1;
      n_checks++; if (q_count !== 4'(exp_cnt)) begin n_fail++; $display("FAIL fill_count_%0d: got %0d expected %0d", i, q_count, exp_cnt); end
      n_checks++; if (host_ready !== (exp_cnt < 8)) begin n_fail++; $display("FAIL fill_ready_%0d: got %0b expected %0b", i, host_ready, exp_cnt < 8); end
    end
    host_valid = 1'b0;
    tick();
    n_checks++; if (mon_addr.size() !== 0) begin n_fail++; $display("FAIL fill_no_issue: got %0d expected 0", mon_addr.size()); end
  endtask

  task automatic test_drain();
    int diff;
    mon_clear();
    resp_en = 1'b1; force_busy = 1'b0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (mon_addr.size() >= 8) break;
    end
    repeat (15) tick();
    n_checks++; if (mon_addr.size() !== 8) begin n_fail++; $display("FAIL drain_pulses: got %0d expected 8", mon_addr.size()); end
    for (int i = 0; i < 8 && i < mon_addr.size(); i++) begin
      n_checks++; if (mon_addr[i] !== 32'h200 + i) begin n_fail++; $display("FAIL drain_addr_%0d: got %0h expected %0h", i, mon_addr[i], 32'h200 + i); end
      n_checks++; if (mon_data[i] !== 64'(i) || mon_rw[i] !== i[0]) begin n_fail++; $display("FAIL drain_entry_%0d: got %0h/%0b expected %0h/%0b", i, mon_data[i], mon_rw[i], i, i[0]); end
      if (i > 0) begin
        diff = mon_cyc[i] - mon_cyc[i-1];
        n_checks++; if (!(diff >= 4)) begin n_fail++; $display("FAIL drain_spacing_%0d: got %0d expected >=4", i, diff); end
      end
    end
    n_checks++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL drain_empty: got %0d expected 0", q_count); end
  endtask

  task automatic test_timeout();
    resp_en = 1'b0; force_busy = 1'b0;
    host_valid = 1'b1; host_rw = 1'b0; host_addr = 32'h300; host_data = 64'h3;
    tick();  // edge N: A accepted
    host_addr = 32'h304; host_data = 64'h4;
    tick();  // edge N+1: B accepted, A issued
    host_valid = 1'b0;
    n_checks++; if (act_cmd !== 1'b1 || out_addr !== 32'h300) begin n_fail++; $display("FAIL tmo_issue_a: got %0b/%0h expected 1/300", act_cmd, out_addr); end
    repeat (16) tick();  // edge N+17
    n_checks++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %0b expected 0", tmo_err); end
    tick();  // edge N+18: BUSY_TMO cycles after WAIT_BUSY entry
    n_checks++; if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %0b expected 1", tmo_err); end
    tick();  // edge N+19: B issues
    n_checks++; if (act_cmd !== 1'b1 || out_addr !== 32'h304) begin n_fail++; $display("FAIL tmo_next_issue: got %0b/%0h expected 1/304", act_cmd, out_addr); end
    repeat (25) tick();
    n_checks++; if (tmo_err !== 1'b1 || q_count !== 4'd0) begin n_fail++; $display("FAIL tmo_sticky: got %0b/%0d expected 1/0", tmo_err, q_count); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    resp_en = 1'b1; force_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_valid = 1'b1; host_rw = 1'b1; host_addr = 32'h400 + i; host_data = 64'(i);
      tick();
    end
    host_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (resp_busy) begin seen = 1'b1; break; end
      tick();
    end
    n_checks++; if (seen !== 1'b1 || q_count !== 4'd3) begin n_fail++; $display("FAIL rm_wait_done: got %0b/%0d expected 1/3", seen, q_count); end
    reset = 1'b1;
    #1;
    n_checks++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL rm_async_flush: got %0d expected 0", q_count); end
    n_checks++; if (act_cmd !== 1'b0 || tmo_err !== 1'b0) begin n_fail++; $display("FAIL rm_async_outputs: got %0b/%0b expected 0/0", act_cmd, tmo_err); end
    repeat (2) tick();
    reset = 1'b0;
    mon_clear();
    repeat (30) tick();
    n_checks++; if (mon_addr.size() !== 0) begin n_fail++; $display("FAIL rm_no_issue: got %0d expected 0", mon_addr.size()); end
    host_valid = 1'b1; host_rw = 1'b0; host_addr = 32'h500; host_data = 64'h5;
    tick();
    host_valid = 1'b0;
    tick();
    n_checks++; if (act_cmd !== 1'b1 || out_addr !== 32'h500) begin n_fail++; $display("FAIL rm_new_issue: got %0b/%0h expected 1/500", act_cmd, out_addr); end
    repeat (15) tick();
  endtask

  task automatic test_stats();
    logic [4:0] rws;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
    rws = 5'b01010;  // entry i uses bit i: R W R W R
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mon_clear();
    resp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_valid = 1'b1; host_rw = rws[i]; host_addr = 32'h600 + i; host_data = 64'(i);
      tick();
    end
    host_valid = 1'b0;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (mon_addr.size() >= 5) break;
    end
    repeat (15) tick();
`ifdef DDR_REQ_STATS_EN
    exp_rd = 16'd3; exp_wr = 16'd2;
`else
    exp_rd = 16'd0; exp_wr = 16'd0;
`endif
    n_checks++; if (mon_addr.size() !== 5) begin n_fail++; $display("FAIL stats_pulses: got %0d expected 5", mon_addr.size()); end
    n_checks++; if (rd_cnt !== exp_rd) begin n_fail++; $display("FAIL stats_rd_cnt: got %0d expected %0d", rd_cnt, exp_rd); end
    n_checks++; if (wr_cnt !== exp_wr) begin n_fail++; $display("FAIL stats_wr_cnt: got %0d expected %0d", wr_cnt, exp_wr); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill();
    test_drain();
    test_timeout();
    test_reset_mid();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
